// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - shared op encodings, state type and constants for the EX multiply/divide sequencer
package ex_mdu_pkg;

  localparam logic [1:0] MDU_MUL  = 2'b00;
  localparam logic [1:0] MDU_MULH = 2'b01;
  localparam logic [1:0] MDU_DIV  = 2'b10;
  localparam logic [1:0] MDU_REM  = 2'b11;

  localparam int MDU_ITER = 16;

  // Quotient reported when dividing by zero
  localparam logic [15:0] MDU_DIV0_Q = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MUL_RUN = 2'b01,
    ST_DIV_RUN = 2'b10,
    ST_DONE    = 2'b11
  } mdu_state_t;

  // Ops with bit 1 set are divide-class (DIV/REM)
  function automatic logic mdu_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_mdu_step.sv
// rtl/ex_mdu_step.sv - one combinational shift-add / restoring-divide iteration (divide path built only with EX_MDU_DIV_EN)
module mdu_step #(
  parameter int WIDTH = 16
) (
  input  logic             div_mode,
  input  logic [WIDTH:0]   hi_r,
  input  logic [WIDTH-1:0] lo_q,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH:0]   hi_r_next,
  output logic [WIDTH-1:0] lo_q_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] r_diff;

  // R never exceeds the divisor before the shift, so the top bit of hi_r carries no information
  logic unused_step;
  assign unused_step = ^{div_mode, hi_r[WIDTH]};

  // Multiply step by default; a divide step overrides it when the divide path is built
  always_comb begin
    mul_sum   = {1'b0, hi_r[WIDTH-1:0]} + (lo_q[0] ? {1'b0, op_b} : '0);
    hi_r_next = {1'b0, mul_sum[WIDTH:1]};
    lo_q_next = {mul_sum[0], lo_q[WIDTH-1:1]};
    r_shift   = '0;
    r_diff    = '0;
`ifdef EX_MDU_DIV_EN
    if (div_mode) begin
      r_shift = {hi_r[WIDTH-1:0], lo_q[WIDTH-1]};
      r_diff  = {1'b0, r_shift} - {2'b00, op_b};
      if (!r_diff[WIDTH+1]) begin
        hi_r_next = r_diff[WIDTH:0];
        lo_q_next = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_r_next = r_shift;
        lo_q_next = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/ex_mdu_ctrl.sv
// rtl/ex_mdu_ctrl.sv - EX-stage multi-cycle MUL/MULH/DIV/REM sequencer (divide support under EX_MDU_DIV_EN)
module ex_mdu_ctrl
  import ex_mdu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = MDU_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = $clog2(ITER) + 1;

  mdu_state_t       state, state_next;
  logic             sel_hi_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             last_iter;

  assign last_iter = (cnt_q == CW'(ITER - 1));
  assign result    = result_q;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_mode  (state == ST_DIV_RUN),
    .hi_r      (hi_q),
    .lo_q      (lo_q),
    .op_b      (b_q),
    .hi_r_next (step_hi),
    .lo_q_next (step_lo)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state and status outputs; flush overrides any transition
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = start;
        if (start) begin
          if (!mdu_is_div(op)) begin
            state_next = ST_MUL_RUN;
          end else begin
`ifdef EX_MDU_DIV_EN
            state_next = (op_b != '0) ? ST_DIV_RUN : ST_DONE;
`else
            state_next = ST_DONE;
`endif
          end
        end
      end
      ST_MUL_RUN: begin
        busy  = 1'b1;
        stall = 1'b1;
        if (last_iter) state_next = ST_DONE;
      end
`ifdef EX_MDU_DIV_EN
      ST_DIV_RUN: begin
        busy  = 1'b1;
        stall = 1'b1;
        if (last_iter) state_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

`ifdef EX_MDU_DIV_EN
  logic div_zero_q;
  assign div_zero = div_zero_q;

  // Divide-by-zero flag: cleared on accept, set when a divide request has a zero divisor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_zero_q <= 1'b0;
    end else if (!flush && state == ST_IDLE && start) begin
      div_zero_q <= mdu_is_div(op) && (op_b == '0);
    end
  end
`else
  assign div_zero = 1'b0;
`endif

  // Operand capture, iteration registers, counter and committed result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_hi_q <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_hi_q <= op[0];
            b_q      <= op_b;
            hi_q     <= '0;
            lo_q     <= op_a;
            cnt_q    <= '0;
`ifdef EX_MDU_DIV_EN
            if (mdu_is_div(op) && op_b == '0)
              result_q <= (op == MDU_DIV) ? MDU_DIV0_Q : op_a;
`else
            if (mdu_is_div(op))
              result_q <= '0;
`endif
          end
        end
        ST_MUL_RUN, ST_DIV_RUN: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            cnt_q    <= '0;
            // Even ops (MUL, DIV) report the low/quotient half, odd ops the high/remainder half
            result_q <= sel_hi_q ? step_hi[WIDTH-1:0] : step_lo;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// tb/tb_ex_mdu_ctrl.sv - randomized self-checking bench for ex_mdu_ctrl against an arithmetic reference model
module tb_ex_mdu_ctrl;
  import ex_mdu_pkg::*;

`ifdef EX_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [15:0] result;
  logic        div_zero;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] last_res = '0;
  logic        last_dz = 1'b0;

  ex_mdu_ctrl #(.WIDTH(16), .ITER(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_res(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    if (o == MDU_MUL)  return p[15:0];
    if (o == MDU_MULH) return p[31:16];
    if (!DIV_EN)       return 16'h0000;
    if (b == 16'h0)    return (o == MDU_DIV) ? 16'hFFFF : a;
    if (o == MDU_DIV)  return a / b;
    return a % b;
  endfunction

  // Called at a negedge; inj_k > 0 re-pulses start with other operands ahead of edge N+inj_k
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input int inj_k, input string tag);
    int lat, stalls, elat;
    logic [15:0] er;
    logic edz;
    er   = model_res(o, a, b);
    edz  = DIV_EN && o[1] && (b == 16'h0);
    elat = (o[1] && (b == 16'h0 || !DIV_EN)) ? 0 : 16;
    start = 1'b1; op = o; op_a = a; op_b = b;
    #1;
    check({tag, ".stall_accept"}, stall, 1);
    @(posedge clk);
    stalls = 1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k - 1;
        break;
      end
      stalls += int'(stall);
      start = (k == inj_k);
      if (k == inj_k) begin
        op = ~o; op_a = ~a; op_b = a;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, lat, elat);
    check({tag, ".stall_cycles"}, stalls, 1 + elat);
    check({tag, ".result"}, result, er);
    check({tag, ".div_zero"}, div_zero, edz);
    check({tag, ".stall_done"}, stall, 0);
    check({tag, ".busy_done"}, busy, 1);
    last_res = er;
    last_dz  = edz;
    @(negedge clk);
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".idle"}, busy, 0);
  endtask

  task automatic run_flush(input logic [15:0] a, input logic [15:0] b);
    int pulses;
    start = 1'b1; op = MDU_MUL; op_a = a; op_b = b;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (k == 5);
    end
    @(negedge clk);
    flush = 1'b0;
    last_dz = 1'b0;
    check("flush.busy", busy, 0);
    check("flush.result_kept", result, last_res);
    check("flush.div_zero", div_zero, last_dz);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      pulses += int'(done);
    end
    check("flush.no_done", pulses, 0);
  endtask

  task automatic run_reset_mid();
    start = 1'b1; op = MDU_MUL; op_a = 16'h5A5A; op_b = 16'h0303;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid.busy", busy, 0);
    check("rst_mid.result", result, 0);
    check("rst_mid.done", done, 0);
    check("rst_mid.div_zero", div_zero, 0);
    @(negedge clk);
    rst = 1'b1;
    last_res = '0;
    last_dz  = 1'b0;
    @(negedge clk);
    check("rst_mid.idle_after", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.div_zero", div_zero, 0);
    check("reset.result", result, 0);
    check("reset.stall", stall, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(MDU_MUL,  16'h0123, 16'h0045, 0, "mul_small");
    run_op(MDU_MULH, 16'h0123, 16'h0045, 0, "mulh_small");
    run_op(MDU_MUL,  16'hFFFF, 16'hFFFF, 0, "mul_max");
    run_op(MDU_MULH, 16'hFFFF, 16'hFFFF, 0, "mulh_max");
    run_op(MDU_DIV,  16'h03E8, 16'h0007, 0, "div");
    run_op(MDU_REM,  16'h03E8, 16'h0007, 0, "rem");
    run_op(MDU_DIV,  16'h1234, 16'h0000, 0, "div_zero");
    run_op(MDU_REM,  16'h1234, 16'h0000, 0, "rem_zero");
    run_op(MDU_DIV,  16'hFFFF, 16'h0001, 0, "div_one");
    run_op(MDU_MUL,  16'h1111, 16'h0203, 3, "mul_restart_ignored");
    run_op(MDU_REM,  16'h0042, 16'h0000, 0, "rem_zero_pre_flush");
    run_flush(16'h7777, 16'h0123);
    run_op(MDU_MULH, 16'hABCD, 16'h1357, 0, "mulh_after_flush");
    run_reset_mid();
    run_op(MDU_MUL,  16'h00FF, 16'h0101, 0, "mul_after_reset");

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = rb >> 10;
      run_op(ro, ra, rb, 0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
